// File: rtl/frac_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frac_clk_gen
//  Description : Multi-channel fractional clock generator. Each channel runs
//                an ACC_W-bit phase accumulator that advances by a
//                programmable increment every refclk cycle. The carry-out of
//                the add becomes a one-cycle enable pulse (outclk_en), and the
//                accumulator MSB becomes a square wave (outclk). The output
//                frequency is f_refclk * inc / 2^ACC_W.
//
//                A lock counter restarts on every valid configuration write.
//                Outputs are held at 0 until the counter has run LOCK_CYCLES
//                cycles, but the accumulators keep running while unlocked.
//
//  Ports       : refclk    - single clock, rising edge
//                rst       - synchronous active-high reset
//                cfg_we    - configuration write strobe
//                cfg_ch    - channel targeted by the write
//                cfg_inc   - phase increment to load
//                cfg_phase - initial accumulator value to load
//                ch_en     - per-channel run enable
//                outclk_en - per-channel one-cycle wrap pulse
//                outclk    - per-channel square wave (accumulator MSB)
//                locked    - configuration settled, outputs valid
//
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_clk_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    localparam int c_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [c_CH_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int                 c_LCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_LCK_W-1:0] c_LOCK_MAX = c_LCK_W'(LOCK_CYCLES);

    // ------------------------------------------------------------------
    // Write qualification: when NUM_CH is not a power of two the channel
    // field can address non-existent channels; such writes are dropped.
    // ------------------------------------------------------------------
    logic [31:0] w_cfg_ch_ext;
    logic        w_wr_valid;

    assign w_cfg_ch_ext = 32'(cfg_ch);
    assign w_wr_valid   = cfg_we && (w_cfg_ch_ext < 32'(NUM_CH));

    // ------------------------------------------------------------------
    // Lock counter: restarts on every valid write, saturates at the top.
    // locked_d is the next-cycle lock state; the channel output registers
    // use it so that their gating lines up with the registered locked.
    // ------------------------------------------------------------------
    logic [c_LCK_W-1:0] lock_cnt_q;
    logic [c_LCK_W-1:0] lock_cnt_d;
    logic               locked_q;
    logic               locked_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (w_wr_valid) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != c_LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + c_LCK_W'(1);
        end
        locked_d = (lock_cnt_d == c_LOCK_MAX);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

    // ------------------------------------------------------------------
    // Per-channel phase accumulators
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ACC_W-1:0] inc_q;
        logic [ACC_W-1:0] inc_d;
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] acc_d;
        logic             en_q;
        logic             en_d;
        logic             clk_q;
        logic             clk_d;
        logic [ACC_W:0]   w_sum;
        logic             w_sel;

        assign w_sel = w_wr_valid && (cfg_ch == c_CH_W'(gi));
        // One extra bit captures the wrap carry.
        assign w_sum = {1'b0, acc_q} + {1'b0, inc_q};

        always_comb begin
            inc_d = inc_q;
            acc_d = acc_q;
            en_d  = 1'b0;
            if (w_sel) begin
                // A write replaces the add for this cycle; no pulse.
                inc_d = cfg_inc;
                acc_d = cfg_phase;
            end else if (ch_en[gi]) begin
                acc_d = w_sum[ACC_W-1:0];
                en_d  = w_sum[ACC_W];
            end
            // A disabled channel keeps acc, so the MSB tracks the held value.
            clk_d = acc_d[ACC_W-1] & locked_d;
            en_d  = en_d & locked_d;
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                inc_q <= '0;
                acc_q <= '0;
                en_q  <= 1'b0;
                clk_q <= 1'b0;
            end else begin
                inc_q <= inc_d;
                acc_q <= acc_d;
                en_q  <= en_d;
                clk_q <= clk_d;
            end
        end

        assign outclk_en[gi] = en_q;
        assign outclk[gi]    = clk_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_frac_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frac_clk_gen
//  Description : Directed self-checking bench for frac_clk_gen, built with
//                three channels so that channel index 3 is out of range.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frac_clk_gen;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_inc;
    logic [31:0] cfg_phase;
    logic [2:0]  ch_en;
    logic [2:0]  outclk_en;
    logic [2:0]  outclk;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;

    // Reference for the channel-0 resume check
    logic [31:0] model_acc;
    logic [31:0] model_inc;
    logic        model_en;
    logic [32:0] model_sum;

    always #5 refclk = ~refclk;

    frac_clk_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .ch_en     (ch_en),
        .outclk_en (outclk_en),
        .outclk    (outclk),
        .locked    (locked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] inc, input logic [31:0] ph);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = 2'd0;
        cfg_inc   = '0;
        cfg_phase = '0;
        ch_en     = 3'b000;

        // ---------------- reset and power-up lock ----------------
        repeat (3) tick();
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_en", 64'(outclk_en), 64'd0);
        check("rst_clk", 64'(outclk), 64'd0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("por_locked[%0d]", k), 64'(locked), (k == 16) ? 64'd1 : 64'd0);
            check($sformatf("por_en[%0d]", k), 64'(outclk_en), 64'd0);
            check($sformatf("por_clk[%0d]", k), 64'(outclk), 64'd0);
        end

        // ---------------- quarter rate on ch0 ----------------
        ch_en = 3'b001;
        cfg_write(2'd0, 32'h4000_0000, 32'h0000_0000);
        check("qr_unlock", 64'(locked), 64'd0);
        for (int j = 1; j <= 23; j++) begin
            tick();
            if (j < 16) begin
                check($sformatf("qr_locked[%0d]", j), 64'(locked), 64'd0);
                check($sformatf("qr_gated_clk[%0d]", j), 64'(outclk), 64'd0);
            end else begin
                check($sformatf("qr_locked[%0d]", j), 64'(locked), 64'd1);
                check($sformatf("qr_en[%0d]", j), 64'(outclk_en), (j % 4 == 0) ? 64'd1 : 64'd0);
                check($sformatf("qr_clk[%0d]", j), 64'(outclk), (j % 4 >= 2) ? 64'd1 : 64'd0);
            end
        end

        // ---------------- half rate, antiphase ch1/ch2 ----------------
        // ch1 is held disabled while ch2 is written so both start aligned.
        ch_en = 3'b001;
        cfg_write(2'd1, 32'h8000_0000, 32'h8000_0000);
        check("hr_unlock", 64'(locked), 64'd0);
        cfg_write(2'd2, 32'h8000_0000, 32'h0000_0000);
        ch_en = 3'b111;
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (j == 15) check("hr_locked15", 64'(locked), 64'd0);
            if (j >= 16) begin
                check($sformatf("hr_locked[%0d]", j), 64'(locked), 64'd1);
                check($sformatf("hr_en[%0d]", j), 64'(outclk_en[2:1]), (j % 2 == 1) ? 64'd1 : 64'd2);
                check($sformatf("hr_clk[%0d]", j), 64'(outclk[2:1]), (j % 2 == 0) ? 64'd1 : 64'd2);
            end
        end

        // ---------------- reconfigure ch0 mid-run (edge j=20) ----------------
        cfg_write(2'd0, 32'h2000_0000, 32'h0000_0000);
        check("rc_unlock", 64'(locked), 64'd0);
        for (int j = 21; j <= 37; j++) begin
            tick();
            if (j == 35) check("rc_locked35", 64'(locked), 64'd0);
            if (j == 36) begin
                check("rc_locked36", 64'(locked), 64'd1);
                check("rc_en36", 64'(outclk_en), 64'h5);
                check("rc_clk36", 64'(outclk), 64'h2);
            end
            if (j == 37) begin
                check("rc_en37", 64'(outclk_en), 64'h2);
                check("rc_clk37", 64'(outclk), 64'h4);
            end
        end

        // ---------------- illegal channel (edge j=38) ----------------
        cfg_write(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ill_locked", 64'(locked), 64'd1);
        check("ill_en", 64'(outclk_en), 64'h4);
        check("ill_clk", 64'(outclk), 64'h2);

        // ---------------- ch0 paused for 5 cycles ----------------
        model_acc = 32'h4000_0000;
        model_inc = 32'h2000_0000;
        ch_en     = 3'b110;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) ch_en = 3'b111;
            tick();
            if (ch_en[0]) begin
                model_sum = {1'b0, model_acc} + {1'b0, model_inc};
                model_acc = model_sum[31:0];
                model_en  = model_sum[32];
            end else begin
                model_en  = 1'b0;
            end
            check($sformatf("pause_clk0[%0d]", c), 64'(outclk[0]), 64'(model_acc[31]));
            check($sformatf("pause_en0[%0d]", c), 64'(outclk_en[0]), 64'(model_en));
        end

        // ---------------- reset wins over a simultaneous write ----------------
        rst       = 1'b1;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 32'h4000_0000;
        cfg_phase = 32'hC000_0000;
        tick();
        check("rw_locked", 64'(locked), 64'd0);
        check("rw_en", 64'(outclk_en), 64'd0);
        check("rw_clk", 64'(outclk), 64'd0);
        rst    = 1'b0;
        cfg_we = 1'b0;
        ch_en  = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("rw_locked15", 64'(locked), 64'd0);
            if (k >= 16) begin
                check($sformatf("rw_relock[%0d]", k), 64'(locked), 64'd1);
                check($sformatf("rw_idle_en[%0d]", k), 64'(outclk_en), 64'd0);
                check($sformatf("rw_idle_clk[%0d]", k), 64'(outclk), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
